// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants and helpers for the LBP pipeline
package lbp_pkg;

    localparam int P      = 8;
    localparam int FRAC_W = 16;
    localparam int PIX_W  = 8;
    localparam int SAMP_W = PIX_W + FRAC_W;

    localparam logic [3:0] RIU2_NONUNIFORM = 4'd9;

    // Neighbour indices, counter-clockwise from 0 degrees
    localparam int NB_0DEG   = 1;
    localparam int NB_45DEG  = 2;
    localparam int NB_90DEG  = 3;
    localparam int NB_135DEG = 4;
    localparam int NB_180DEG = 5;
    localparam int NB_225DEG = 6;
    localparam int NB_270DEG = 7;
    localparam int NB_315DEG = 8;

    function automatic logic [3:0] popcount8(input logic [P-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < P; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lbp_uniform_map.sv
// rtl/lbp_uniform_map.sv - maps an LBP code to its riu2 label and uniform flag
module lbp_uniform_map
    import lbp_pkg::*;
(
    input  logic [P-1:0] code,
    output logic [3:0]   riu2,
    output logic         uniform
);

    logic [P-1:0] code_rot;
    logic [3:0]   trans;
    logic [3:0]   ones;

    // Rotating by one and XORing marks every circular 0/1 transition
    assign code_rot = {code[0], code[P-1:1]};
    assign trans    = popcount8(code ^ code_rot);
    assign ones     = popcount8(code);

    // Uniform patterns keep their popcount; everything else collapses to one label
    always_comb begin
        uniform = (trans <= 4'd2);
        riu2    = uniform ? ones : RIU2_NONUNIFORM;
    end

endmodule

// File: rtl/lbp_code_gen.sv
// rtl/lbp_code_gen.sv - LBP code, riu2 label and frame pixel count generator
module lbp_code_gen
    import lbp_pkg::*;
#(
    parameter int CENTER_DLY = 3,
    parameter int CNT_W      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                done_i,
    input  logic                progress_done_i,
    input  logic [PIX_W-1:0]    center_i,
    input  logic [SAMP_W-1:0]   S1_i,
    input  logic [SAMP_W-1:0]   S2_i,
    input  logic [SAMP_W-1:0]   S3_i,
    input  logic [SAMP_W-1:0]   S4_i,
    input  logic [SAMP_W-1:0]   S5_i,
    input  logic [SAMP_W-1:0]   S6_i,
    input  logic [SAMP_W-1:0]   S7_i,
    input  logic [SAMP_W-1:0]   S8_i,
    output logic [P-1:0]        code_o,
    output logic [3:0]          riu2_o,
    output logic                uniform_o,
    output logic                valid_o,
    output logic                progress_done_o,
    output logic [CNT_W-1:0]    pixel_cnt_o
);

    logic [PIX_W-1:0]  center_d;
    logic [SAMP_W-1:0] samp [P];
    logic [SAMP_W-1:0] center_ref;
    logic [P-1:0]      code_nxt;
    logic [P-1:0]      code_r;
    logic              done_r;
    logic              pd_r;
    logic [3:0]        riu2_nxt;
    logic              uniform_nxt;
    logic              clr_pend;

    generate
        if (CENTER_DLY == 0) begin : g_no_dly
            assign center_d = center_i;
        end else begin : g_dly
            logic [PIX_W-1:0] dly [CENTER_DLY];

            // Centre pixel shift register matching the interpolator latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < CENTER_DLY; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= center_i;
                    for (int i = 1; i < CENTER_DLY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign center_d = dly[CENTER_DLY-1];
        end
    endgenerate

    assign samp[NB_0DEG-1]   = S1_i;
    assign samp[NB_45DEG-1]  = S2_i;
    assign samp[NB_90DEG-1]  = S3_i;
    assign samp[NB_135DEG-1] = S4_i;
    assign samp[NB_180DEG-1] = S5_i;
    assign samp[NB_225DEG-1] = S6_i;
    assign samp[NB_270DEG-1] = S7_i;
    assign samp[NB_315DEG-1] = S8_i;

    // Centre widened to 8.16 so fractional neighbour bits take part in the compare
    assign center_ref = {center_d, {FRAC_W{1'b0}}};

    // Thresholding of each neighbour against the centre; equality counts as set
    always_comb begin
        code_nxt = '0;
        for (int k = 0; k < P; k++) begin
            code_nxt[k] = (samp[k] >= center_ref);
        end
    end

    // Stage 1: raw code and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= '0;
            done_r <= 1'b0;
            pd_r   <= 1'b0;
        end else begin
            code_r <= code_nxt;
            done_r <= done_i;
            pd_r   <= progress_done_i;
        end
    end

    lbp_uniform_map u_map (
        .code    (code_r),
        .riu2    (riu2_nxt),
        .uniform (uniform_nxt)
    );

    // Stage 2: labelled outputs and delayed strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_o          <= '0;
            riu2_o          <= '0;
            uniform_o       <= 1'b0;
            valid_o         <= 1'b0;
            progress_done_o <= 1'b0;
        end else begin
            code_o          <= code_r;
            riu2_o          <= riu2_nxt;
            uniform_o       <= uniform_nxt;
            valid_o         <= done_r;
            progress_done_o <= pd_r;
        end
    end

    // Frame pixel counter; the end-of-frame pixel is shown for one cycle before the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_cnt_o <= '0;
            clr_pend    <= 1'b0;
        end else begin
            clr_pend <= progress_done_o;
            if (clr_pend) begin
                pixel_cnt_o <= valid_o ? CNT_W'(1) : '0;
            end else if (valid_o && (pixel_cnt_o != {CNT_W{1'b1}})) begin
                pixel_cnt_o <= pixel_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lbp_code_gen.sv
// tb/tb_lbp_code_gen.sv - directed table-driven bench for lbp_code_gen
module tb_lbp_code_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        done_i;
    logic        progress_done_i;
    logic [7:0]  center_i;
    logic [7:0]  center2_i;
    logic [23:0] S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i;

    logic [7:0]  code_o, code2_o;
    logic [3:0]  riu2_o, riu22_o;
    logic        uniform_o, uniform2_o;
    logic        valid_o, valid2_o;
    logic        pd_o, pd2_o;
    logic [19:0] cnt_o;
    logic [2:0]  cnt2_o;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lbp_code_gen #(.CENTER_DLY(3), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .done_i(done_i), .progress_done_i(progress_done_i),
        .center_i(center_i),
        .S1_i(S1_i), .S2_i(S2_i), .S3_i(S3_i), .S4_i(S4_i),
        .S5_i(S5_i), .S6_i(S6_i), .S7_i(S7_i), .S8_i(S8_i),
        .code_o(code_o), .riu2_o(riu2_o), .uniform_o(uniform_o), .valid_o(valid_o),
        .progress_done_o(pd_o), .pixel_cnt_o(cnt_o)
    );

    lbp_code_gen #(.CENTER_DLY(0), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .done_i(done_i), .progress_done_i(progress_done_i),
        .center_i(center2_i),
        .S1_i(S1_i), .S2_i(S2_i), .S3_i(S3_i), .S4_i(S4_i),
        .S5_i(S5_i), .S6_i(S6_i), .S7_i(S7_i), .S8_i(S8_i),
        .code_o(code2_o), .riu2_o(riu22_o), .uniform_o(uniform2_o), .valid_o(valid2_o),
        .progress_done_o(pd2_o), .pixel_cnt_o(cnt2_o)
    );

    typedef struct {
        logic [7:0]  center;
        logic [7:0]  hi_mask;
        logic [23:0] hi;
        logic [23:0] lo;
        logic [7:0]  exp_code;
        logic [3:0]  exp_riu2;
        logic        exp_uni;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic [7:0] mask, input logic [23:0] hi, input logic [23:0] lo);
        S1_i = mask[0] ? hi : lo;
        S2_i = mask[1] ? hi : lo;
        S3_i = mask[2] ? hi : lo;
        S4_i = mask[3] ? hi : lo;
        S5_i = mask[4] ? hi : lo;
        S6_i = mask[5] ? hi : lo;
        S7_i = mask[6] ? hi : lo;
        S8_i = mask[7] ? hi : lo;
    endtask

    initial begin
        vecs[0] = '{8'd100, 8'hFF, {8'd100, 16'h0000}, {8'd100, 16'h0000}, 8'hFF, 4'd8, 1'b1};
        vecs[1] = '{8'd100, 8'hFC, {8'd101, 16'h0000}, {8'd99, 16'hFFFF}, 8'hFC, 4'd6, 1'b1};
        vecs[2] = '{8'd100, 8'h55, {8'd120, 16'h0000}, {8'd80, 16'h0000}, 8'h55, 4'd9, 1'b0};
        vecs[3] = '{8'd255, 8'h00, {8'd255, 16'h0000}, {8'd254, 16'hFFFF}, 8'h00, 4'd0, 1'b1};
        vecs[4] = '{8'd50,  8'h01, {8'd50, 16'h0001}, {8'd49, 16'hFFFF}, 8'h01, 4'd1, 1'b1};
        vecs[5] = '{8'd10,  8'h09, {8'd200, 16'h0000}, {8'd0, 16'h0000}, 8'h09, 4'd9, 1'b0};
        vecs[6] = '{8'd200, 8'hF0, {8'd210, 16'h0000}, {8'd10, 16'h0000}, 8'hF0, 4'd4, 1'b1};
        vecs[7] = '{8'd77,  8'h81, {8'd77, 16'h0000}, {8'd76, 16'h8000}, 8'h81, 4'd2, 1'b1};

        rst_n = 1'b0;
        done_i = 1'b0;
        progress_done_i = 1'b0;
        center_i = 8'd0;
        center2_i = 8'd100;
        drive_s(8'h00, 24'h0, 24'h0);
        step();
        step();
        chk("reset code_o", {24'd0, code_o}, 32'd0);
        chk("reset riu2_o", {28'd0, riu2_o}, 32'd0);
        chk("reset uniform_o", {31'd0, uniform_o}, 32'd0);
        chk("reset valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset progress_done_o", {31'd0, pd_o}, 32'd0);
        chk("reset pixel_cnt_o", {12'd0, cnt_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Table: centre leads neighbours by three cycles
        for (int i = 0; i < 8; i++) begin
            center_i = vecs[i].center;
            step();
            center_i = 8'hAA;
            step();
            step();
            drive_s(vecs[i].hi_mask, vecs[i].hi, vecs[i].lo);
            done_i = 1'b1;
            step();
            done_i = 1'b0;
            drive_s(8'h00, 24'h0, 24'h0);
            step();
            chk($sformatf("vec%0d code_o", i), {24'd0, code_o}, {24'd0, vecs[i].exp_code});
            chk($sformatf("vec%0d riu2_o", i), {28'd0, riu2_o}, {28'd0, vecs[i].exp_riu2});
            chk($sformatf("vec%0d uniform_o", i), {31'd0, uniform_o}, {31'd0, vecs[i].exp_uni});
            chk($sformatf("vec%0d valid_o", i), {31'd0, valid_o}, 32'd1);
            step();
            chk($sformatf("vec%0d valid_o drop", i), {31'd0, valid_o}, 32'd0);
        end

        // Clear counters with a lone end-of-frame strobe
        progress_done_i = 1'b1;
        step();
        progress_done_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("clear pixel_cnt_o", {12'd0, cnt_o}, 32'd0);
        chk("clear small pixel_cnt_o", {29'd0, cnt2_o}, 32'd0);

        // Six back-to-back pixels, last one carries end-of-frame
        for (int cyc = 0; cyc < 11; cyc++) begin
            logic [31:0] exp_cnt;
            exp_cnt = (cyc >= 3 && cyc <= 8) ? 32'(cyc - 2) : 32'd0;
            chk($sformatf("frame c%0d valid_o", cyc), {31'd0, valid_o}, (cyc >= 2 && cyc <= 7) ? 32'd1 : 32'd0);
            chk($sformatf("frame c%0d progress_done_o", cyc), {31'd0, pd_o}, (cyc == 7) ? 32'd1 : 32'd0);
            chk($sformatf("frame c%0d pixel_cnt_o", cyc), {12'd0, cnt_o}, exp_cnt);
            chk($sformatf("frame c%0d small pixel_cnt_o", cyc), {29'd0, cnt2_o}, exp_cnt);
            done_i = (cyc < 6);
            progress_done_i = (cyc == 5);
            step();
        end
        done_i = 1'b0;
        progress_done_i = 1'b0;

        // Nine pixels in one frame: narrow counter saturates
        for (int i = 0; i < 9; i++) begin
            done_i = 1'b1;
            step();
        end
        done_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("sat small pixel_cnt_o", {29'd0, cnt2_o}, 32'd7);
        chk("wide pixel_cnt_o", {12'd0, cnt_o}, 32'd9);
        step();
        chk("sat hold small pixel_cnt_o", {29'd0, cnt2_o}, 32'd7);

        // Asynchronous reset with two pixels in flight
        drive_s(8'hFF, {8'd255, 16'hFFFF}, 24'h0);
        done_i = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async code_o", {24'd0, code_o}, 32'd0);
        chk("async riu2_o", {28'd0, riu2_o}, 32'd0);
        chk("async uniform_o", {31'd0, uniform_o}, 32'd0);
        chk("async valid_o", {31'd0, valid_o}, 32'd0);
        chk("async progress_done_o", {31'd0, pd_o}, 32'd0);
        chk("async pixel_cnt_o", {12'd0, cnt_o}, 32'd0);
        done_i = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post-reset c%0d valid_o", i), {31'd0, valid_o}, 32'd0);
            chk($sformatf("post-reset c%0d pixel_cnt_o", i), {12'd0, cnt_o}, 32'd0);
            step();
        end

        // Fresh pixel after reset flows through normally
        center_i = 8'd100;
        step();
        step();
        step();
        drive_s(8'hFF, {8'd100, 16'h0000}, 24'h0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        step();
        chk("post-reset pixel valid_o", {31'd0, valid_o}, 32'd1);
        chk("post-reset pixel code_o", {24'd0, code_o}, 32'h0000_00FF);
        step();
        chk("post-reset pixel_cnt_o", {12'd0, cnt_o}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
